ifu_pf: RTL



---
 rtl/ifu_pf_if.sv | 40 ++++
 rtl/ifu_pf.sv | 132 +++++++++++++
 2 files changed

// File: rtl/ifu_pf_if.sv
// Bundle of the fetch-unit channels: instruction memory port, execute-stage port and flush.
// The master modport is the fetch unit's view; slave is the environment (memory + execute).
interface ifu_pf_if #(
  parameter int PC_W = 32,
  parameter int IR_W = 32
);
  logic            fch_req_vld;
  logic            fch_req_rdy;
  logic [PC_W-1:0] fch_req_pc;
  logic            fch_rsp_vld;
  logic            fch_rsp_rdy;
  logic [IR_W-1:0] fch_rsp_ir;
  logic            ex_req_vld;
  logic            ex_req_rdy;
  logic [IR_W-1:0] ex_req_ir;
  logic [PC_W-1:0] ex_req_pc;
  logic            ex_req_pred_taken;
  logic [PC_W-1:0] ex_req_pred_pc;
  logic            ex_rsp_vld;
  logic            ex_rsp_rdy;
  logic            ex_rsp_taken;
  logic [PC_W-1:0] ex_rsp_target_pc;
  logic            fl_req_vld;

  modport master (
    output fch_req_vld, fch_req_pc, fch_rsp_rdy,
    output ex_req_vld, ex_req_ir, ex_req_pc, ex_req_pred_taken, ex_req_pred_pc,
    output ex_rsp_rdy, fl_req_vld,
    input  fch_req_rdy, fch_rsp_vld, fch_rsp_ir,
    input  ex_req_rdy, ex_rsp_vld, ex_rsp_taken, ex_rsp_target_pc
  );

  modport slave (
    input  fch_req_vld, fch_req_pc, fch_rsp_rdy,
    input  ex_req_vld, ex_req_ir, ex_req_pc, ex_req_pred_taken, ex_req_pred_pc,
    input  ex_rsp_rdy, fl_req_vld,
    output fch_req_rdy, fch_rsp_vld, fch_rsp_ir,
    output ex_req_rdy, ex_rsp_vld, ex_rsp_taken, ex_rsp_target_pc
  );
endinterface

// File: rtl/ifu_pf.sv
// Prefetching instruction fetch unit: several fetches in flight, an instruction buffer
// towards execute, and redirect on taken branches with discard of stale responses.
module ifu_pf #(
  parameter int              PC_W       = 32,
  parameter int              IR_W       = 32,
  parameter logic [PC_W-1:0] RESET_PC   = PC_W'(32'h4000_0000),
  parameter int              PC_INC     = 4,
  parameter int              MAX_OUTST  = 2,
  parameter int              IBUF_DEPTH = 4
) (
  input logic     clk,
  input logic     rst,
  ifu_pf_if.master bus
);
  localparam int OC_W = $clog2(MAX_OUTST + 1);
  localparam int IC_W = $clog2(IBUF_DEPTH + 1);
  localparam int PP_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int IP_W = (IBUF_DEPTH > 1) ? $clog2(IBUF_DEPTH) : 1;
  localparam int CR_W = ((OC_W > IC_W) ? OC_W : IC_W) + 1;

  logic [PC_W-1:0] fpc_q, fpc_d;
  logic [OC_W-1:0] outst_q, outst_d;
  logic [OC_W-1:0] drop_q, drop_d;
  logic [PC_W-1:0] pf_mem [MAX_OUTST];
  logic [PP_W-1:0] pf_wr_q, pf_rd_q;
  logic [IR_W-1:0] ib_ir [IBUF_DEPTH];
  logic [PC_W-1:0] ib_pc [IBUF_DEPTH];
  logic [IP_W-1:0] ib_wr_q, ib_wr_d, ib_rd_q, ib_rd_d;
  logic [IC_W-1:0] ib_cnt_q, ib_cnt_d;

  logic            flush, req_vld, req_hs, rsp_hs, ib_push, ex_vld, ex_hs;
  logic [CR_W-1:0] credit;

  function automatic logic [PP_W-1:0] pf_inc(input logic [PP_W-1:0] p);
    return (p == PP_W'(MAX_OUTST - 1)) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [IP_W-1:0] ib_inc(input logic [IP_W-1:0] p);
    return (ib_is_last(p)) ? '0 : p + 1'b1;
  endfunction

  function automatic logic ib_is_last(input logic [IP_W-1:0] p);
    return p == IP_W'(IBUF_DEPTH - 1);
  endfunction

  // Slots committed = responses still owed that will be kept + entries already buffered.
  assign credit  = CR_W'(outst_q) - CR_W'(drop_q) + CR_W'(ib_cnt_q);
  assign flush   = !rst && bus.ex_rsp_vld && bus.ex_rsp_taken;
  assign req_vld = !rst && !flush && (outst_q < OC_W'(MAX_OUTST))
                   && (credit < CR_W'(IBUF_DEPTH));
  assign req_hs  = req_vld && bus.fch_req_rdy;
  assign rsp_hs  = !rst && bus.fch_rsp_vld;
  assign ib_push = rsp_hs && !flush && (drop_q == '0);
  assign ex_vld  = !rst && !flush && (ib_cnt_q != '0);
  assign ex_hs   = ex_vld && bus.ex_req_rdy;

  assign bus.fch_req_vld       = req_vld;
  assign bus.fch_req_pc        = fpc_q;
  assign bus.fch_rsp_rdy       = !rst;
  assign bus.ex_rsp_rdy        = !rst;
  assign bus.fl_req_vld        = flush;
  assign bus.ex_req_vld        = ex_vld;
  assign bus.ex_req_ir         = ib_ir[ib_rd_q];
  assign bus.ex_req_pc         = ib_pc[ib_rd_q];
  assign bus.ex_req_pred_taken = 1'b0;
  assign bus.ex_req_pred_pc    = '0;

  always_comb begin
    fpc_d    = fpc_q;
    outst_d  = outst_q;
    drop_d   = drop_q;
    ib_wr_d  = ib_wr_q;
    ib_rd_d  = ib_rd_q;
    ib_cnt_d = ib_cnt_q;
    if (req_hs) outst_d = outst_d + 1'b1;
    if (rsp_hs) outst_d = outst_d - 1'b1;
    if (flush) begin
      // Everything still owed is stale, including a response landing right now.
      fpc_d    = bus.ex_rsp_target_pc;
      drop_d   = outst_q - (rsp_hs ? OC_W'(1) : OC_W'(0));
      ib_wr_d  = '0;
      ib_rd_d  = '0;
      ib_cnt_d = '0;
    end else begin
      if (req_hs) fpc_d = fpc_q + PC_W'(PC_INC);
      if (rsp_hs && drop_q != '0) drop_d = drop_q - 1'b1;
      if (ib_push) ib_wr_d = ib_inc(ib_wr_q);
      if (ex_hs) ib_rd_d = ib_inc(ib_rd_q);
      if (ib_push && !ex_hs) ib_cnt_d = ib_cnt_q + 1'b1;
      if (!ib_push && ex_hs) ib_cnt_d = ib_cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fpc_q    <= RESET_PC;
      outst_q  <= '0;
      drop_q   <= '0;
      pf_wr_q  <= '0;
      pf_rd_q  <= '0;
      ib_wr_q  <= '0;
      ib_rd_q  <= '0;
      ib_cnt_q <= '0;
    end else begin
      assert (!(ib_push && ib_cnt_q == IC_W'(IBUF_DEPTH)));
      fpc_q    <= fpc_d;
      outst_q  <= outst_d;
      drop_q   <= drop_d;
      ib_wr_q  <= ib_wr_d;
      ib_rd_q  <= ib_rd_d;
      ib_cnt_q <= ib_cnt_d;
      if (req_hs) pf_wr_q <= pf_inc(pf_wr_q);
      if (rsp_hs) pf_rd_q <= pf_inc(pf_rd_q);
    end
  end

  // Storage arrays carry no reset; occupancy is tracked by the pointers above.
  for (genvar gi = 0; gi < MAX_OUTST; gi++) begin : g_pf
    always_ff @(posedge clk) begin
      if (req_hs && pf_wr_q == PP_W'(gi)) pf_mem[gi] <= fpc_q;
    end
  end

  for (genvar gi = 0; gi < IBUF_DEPTH; gi++) begin : g_ib
    always_ff @(posedge clk) begin
      if (ib_push && ib_wr_q == IP_W'(gi)) begin
        ib_ir[gi] <= bus.fch_rsp_ir;
        ib_pc[gi] <= pf_mem[pf_rd_q];
      end
    end
  end
endmodule
